// File: rtl/vram_arb_pkg.sv
// rtl/vram_arb_pkg.sv - shared owner tags, CPU FSM states and default widths for vram_arbiter
package vram_arb_pkg;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        VID      = 2'd1,
        VID_LATE = 2'd2,
        CPU      = 2'd3
    } owner_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUED = 2'd1,
        RAM    = 2'd2,
        ACK    = 2'd3
    } cpu_state_t;

    function automatic logic is_vid(input owner_t t);
        return (t == VID) || (t == VID_LATE);
    endfunction

endpackage

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port character RAM arbiter: video fetch priority, starvation-bounded CPU access
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_wait,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    output logic              vid_late,
    output logic              vid_overrun,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [7:0] LP_STARVE_MAX = 8'(STARVE_MAX);

    cpu_state_t        r_state;
    cpu_state_t        w_next_state;
    logic [7:0]        r_starve_cnt;

    logic              r_buf_valid;
    logic [ADDR_W-1:0] r_buf_addr;
    logic              r_buf_late;
    logic              w_buf_valid_nxt;
    logic [ADDR_W-1:0] w_buf_addr_nxt;
    logic              w_buf_late_nxt;

    owner_t            w_issue_tag;
    owner_t            r_tag_ram;
    owner_t            r_tag_ret;
    logic [ADDR_W-1:0] w_issue_addr;
    logic              w_cpu_idle_req;
    logic              w_force;
    logic              w_cpu_grant;
    logic              w_drop;

    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_we;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_cpu_wr;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic              r_cpu_wait;
    logic [DATA_W-1:0] r_vid_data;
    logic              r_vid_valid;
    logic              r_vid_late;
    logic              r_overrun;

    assign w_cpu_idle_req = cpu_req && (r_state == IDLE);
    assign w_force        = w_cpu_idle_req && (r_starve_cnt == LP_STARVE_MAX);

    // Slot selection. A forced CPU grant parks the displaced video candidate in the
    // one-entry buffer; a buffered entry that is displaced again stays and a new request is lost.
    always_comb begin
        w_issue_tag     = NONE;
        w_issue_addr    = r_ram_addr;
        w_cpu_grant     = 1'b0;
        w_drop          = 1'b0;
        w_buf_valid_nxt = r_buf_valid;
        w_buf_addr_nxt  = r_buf_addr;
        w_buf_late_nxt  = r_buf_late;
        if (w_force) begin
            w_issue_tag  = CPU;
            w_issue_addr = cpu_addr;
            w_cpu_grant  = 1'b1;
            if (r_buf_valid) begin
                w_buf_late_nxt = 1'b1;
                w_drop         = vid_req;
            end else if (vid_req) begin
                w_buf_valid_nxt = 1'b1;
                w_buf_addr_nxt  = vid_addr;
                w_buf_late_nxt  = 1'b1;
            end
        end else if (r_buf_valid) begin
            w_issue_tag     = r_buf_late ? VID_LATE : VID;
            w_issue_addr    = r_buf_addr;
            w_buf_valid_nxt = vid_req;
            w_buf_addr_nxt  = vid_req ? vid_addr : r_buf_addr;
            w_buf_late_nxt  = 1'b0;
        end else if (vid_req) begin
            w_issue_tag  = VID;
            w_issue_addr = vid_addr;
        end else if (w_cpu_idle_req) begin
            w_issue_tag  = CPU;
            w_issue_addr = cpu_addr;
            w_cpu_grant  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = w_cpu_grant ? ISSUED : IDLE;
            ISSUED:  w_next_state = RAM;
            RAM:     w_next_state = ACK;
            ACK:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        cpu_ack = (r_state == ACK);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_starve_cnt <= 8'd0;
        end else if (w_cpu_grant || !cpu_req) begin
            r_starve_cnt <= 8'd0;
        end else if ((r_state == IDLE) && (r_starve_cnt != LP_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_late  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_buf_valid <= w_buf_valid_nxt;
            r_buf_addr  <= w_buf_addr_nxt;
            r_buf_late  <= w_buf_late_nxt;
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Issue stage: ram_addr holds across idle slots, the owner tag follows the access.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
            r_cpu_wr    <= 1'b0;
            r_tag_ram   <= NONE;
            r_tag_ret   <= NONE;
        end else begin
            if (w_issue_tag != NONE) begin
                r_ram_addr <= w_issue_addr;
            end
            r_ram_we <= w_cpu_grant && cpu_we;
            if (w_cpu_grant && cpu_we) begin
                r_ram_wdata <= cpu_wdata;
            end
            if (w_cpu_grant) begin
                r_cpu_wr <= cpu_we;
            end
            r_tag_ram <= w_issue_tag;
            r_tag_ret <= r_tag_ram;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cpu_rdata <= '0;
            r_vid_data  <= '0;
            r_vid_valid <= 1'b0;
            r_vid_late  <= 1'b0;
            r_cpu_wait  <= 1'b0;
        end else begin
            if ((r_tag_ret == CPU) && !r_cpu_wr) begin
                r_cpu_rdata <= ram_rdata;
            end
            if (is_vid(r_tag_ret)) begin
                r_vid_data <= ram_rdata;
            end
            r_vid_valid <= is_vid(r_tag_ret);
            r_vid_late  <= (r_tag_ret == VID_LATE);
            r_cpu_wait  <= cpu_req && (w_next_state != ACK);
        end
    end

    assign ram_addr    = r_ram_addr;
    assign ram_we      = r_ram_we;
    assign ram_wdata   = r_ram_wdata;
    assign cpu_rdata   = r_cpu_rdata;
    assign cpu_wait    = r_cpu_wait;
    assign vid_data    = r_vid_data;
    assign vid_valid   = r_vid_valid;
    assign vid_late    = r_vid_late;
    assign vid_overrun = r_overrun;

endmodule
